// File: rtl/coffee_panel.sv
// coffee_panel: front-panel sequencer for a coffee machine.
// Turns power/brew button presses into on/gen requests. It waits for the
// machine to confirm brewing via led, times the brew, and counts finished
// cups. A missing or dropped led confirmation sends the panel to FAULT.
//
// state | meaning
// ------+---------------------------------------------------------------
// OFF   | machine unpowered, waiting for a power press
// IDLE  | powered, waiting for a brew press
// REQ   | brew requested, waiting up to ACK_TIMEOUT cycles for led=1
// BREW  | brewing; led must stay high for BREW_CYCLES cycles
// DONE  | one-cycle completion pulse, cup counted on entry
// FAULT | confirmation lost or never arrived; only a power press leaves
module coffee_panel #(
  parameter int BREW_CYCLES = 8,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_power,
  input  logic       btn_brew,
  input  logic       led,
  output logic       on,
  output logic       gen,
  output logic       done,
  output logic       fault,
  output logic [3:0] cups,
  output logic [2:0] state
);

  localparam int CNT_MAX = (BREW_CYCLES > ACK_TIMEOUT) ? BREW_CYCLES : ACK_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] BREW_LAST = CNT_W'(BREW_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_IDLE  = 3'd1,
    ST_REQ   = 3'd2,
    ST_BREW  = 3'd3,
    ST_DONE  = 3'd4,
    ST_FAULT = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic             power_prev_q, power_prev_d;
  logic             brew_prev_q, brew_prev_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] brew_cnt_q, brew_cnt_d;
  logic [3:0]       cups_q, cups_d;
  logic             on_q, on_d;
  logic             gen_q, gen_d;
  logic             done_q, done_d;
  logic             fault_q, fault_d;

  logic             power_evt;
  logic             brew_evt;

  // Rising-edge events: live button against last cycle's sample
  always_comb begin
    power_prev_d = btn_power;
    brew_prev_d  = btn_brew;
    power_evt    = btn_power & ~power_prev_q;
    brew_evt     = btn_brew & ~brew_prev_q;
  end

  // Next-state, counters and cup count; power press always wins
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    brew_cnt_d = brew_cnt_q;
    cups_d     = cups_q;
    case (state_q)
      ST_OFF: begin
        if (power_evt) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (power_evt) begin
          state_d = ST_OFF;
        end else if (brew_evt) begin
          state_d    = ST_REQ;
          wait_cnt_d = '0;
        end
      end
      ST_REQ: begin
        if (power_evt) begin
          state_d = ST_OFF;
        end else if (led) begin
          state_d    = ST_BREW;
          brew_cnt_d = '0;
        end else if (wait_cnt_q == ACK_LAST) begin
          state_d = ST_FAULT;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_ONE;
        end
      end
      ST_BREW: begin
        if (power_evt) begin
          state_d = ST_OFF;
        end else if (!led) begin
          state_d = ST_FAULT;
        end else if (brew_cnt_q == BREW_LAST) begin
          state_d = ST_DONE;
          if (cups_q != 4'hF) cups_d = cups_q + 4'd1;
        end else begin
          brew_cnt_d = brew_cnt_q + CNT_ONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_FAULT: begin
        if (power_evt) state_d = ST_OFF;
      end
      default: begin
        state_d = ST_OFF;
      end
    endcase
  end

  // Moore outputs decoded from the next state so they register alongside it
  always_comb begin
    on_d    = 1'b0;
    gen_d   = 1'b0;
    done_d  = 1'b0;
    fault_d = 1'b0;
    case (state_d)
      ST_IDLE:  on_d = 1'b1;
      ST_REQ:   begin on_d = 1'b1; gen_d = 1'b1; end
      ST_BREW:  begin on_d = 1'b1; gen_d = 1'b1; end
      ST_DONE:  begin on_d = 1'b1; done_d = 1'b1; end
      ST_FAULT: fault_d = 1'b1;
      default:  on_d = 1'b0;
    endcase
  end

  // State and output registers; history resets high so a held button is not an event
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_OFF;
      power_prev_q <= 1'b1;
      brew_prev_q  <= 1'b1;
      wait_cnt_q   <= '0;
      brew_cnt_q   <= '0;
      cups_q       <= 4'd0;
      on_q         <= 1'b0;
      gen_q        <= 1'b0;
      done_q       <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      power_prev_q <= power_prev_d;
      brew_prev_q  <= brew_prev_d;
      wait_cnt_q   <= wait_cnt_d;
      brew_cnt_q   <= brew_cnt_d;
      cups_q       <= cups_d;
      on_q         <= on_d;
      gen_q        <= gen_d;
      done_q       <= done_d;
      fault_q      <= fault_d;
    end
  end

  assign on    = on_q;
  assign gen   = gen_q;
  assign done  = done_q;
  assign fault = fault_q;
  assign cups  = cups_q;
  assign state = state_q;

endmodule

// File: tb/tb_coffee_panel.sv
// tb_coffee_panel: directed scenarios followed by random button/led traffic,
// all compared against a phase/elapsed-time reference model.
module tb_coffee_panel;

  localparam int BREW_CYCLES = 8;
  localparam int ACK_TIMEOUT = 4;

  localparam int P_OFF   = 0;
  localparam int P_IDLE  = 1;
  localparam int P_REQ   = 2;
  localparam int P_BREW  = 3;
  localparam int P_DONE  = 4;
  localparam int P_FAULT = 5;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       btn_power = 1'b0;
  logic       btn_brew = 1'b0;
  logic       led = 1'b0;
  logic       on, gen, done, fault;
  logic [3:0] cups;
  logic [2:0] state;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: current phase, cycles spent in it, cups, last button levels
  int m_phase = P_OFF;
  int m_age = 0;
  int m_cups = 0;
  bit m_lp = 1'b1;
  bit m_lb = 1'b1;

  coffee_panel #(.BREW_CYCLES(BREW_CYCLES), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clock(clock), .reset(reset), .btn_power(btn_power), .btn_brew(btn_brew),
    .led(led), .on(on), .gen(gen), .done(done), .fault(fault),
    .cups(cups), .state(state)
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    m_phase = P_OFF;
    m_age   = 0;
    m_cups  = 0;
    m_lp    = 1'b1;
    m_lb    = 1'b1;
  endtask

  task automatic model_step(input bit p, input bit b, input bit l);
    bit pe, be;
    int nxt;
    pe = p && !m_lp;
    be = b && !m_lb;
    m_lp = p;
    m_lb = b;
    nxt = m_phase;
    if (pe && m_phase != P_DONE) begin
      nxt = (m_phase == P_OFF) ? P_IDLE : P_OFF;
    end else begin
      case (m_phase)
        P_IDLE:  if (be) nxt = P_REQ;
        P_REQ:   if (l) nxt = P_BREW; else if (m_age + 1 >= ACK_TIMEOUT) nxt = P_FAULT;
        P_BREW:  if (!l) nxt = P_FAULT;
                 else if (m_age + 1 >= BREW_CYCLES) begin
                   nxt = P_DONE;
                   m_cups = (m_cups >= 15) ? 15 : m_cups + 1;
                 end
        P_DONE:  nxt = P_IDLE;
        default: nxt = m_phase;
      endcase
    end
    m_age = (nxt != m_phase) ? 0 : m_age + 1;
    m_phase = nxt;
  endtask

  task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic check_all(input string tag);
    check1({tag, ":state"}, 32'(state), m_phase);
    check1({tag, ":on"},    32'(on),    (m_phase >= P_IDLE && m_phase <= P_DONE) ? 1 : 0);
    check1({tag, ":gen"},   32'(gen),   (m_phase == P_REQ || m_phase == P_BREW) ? 1 : 0);
    check1({tag, ":done"},  32'(done),  (m_phase == P_DONE) ? 1 : 0);
    check1({tag, ":fault"}, 32'(fault), (m_phase == P_FAULT) ? 1 : 0);
    check1({tag, ":cups"},  32'(cups),  m_cups);
  endtask

  task automatic cycle(input string tag);
    @(posedge clock);
    model_step(btn_power, btn_brew, led);
    #1;
    check_all(tag);
  endtask

  task automatic pulse_power();
    btn_power = 1'b1; cycle("pwr");
    btn_power = 1'b0; cycle("pwr_rel");
  endtask

  initial begin
    int n;
    // Reset state
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_all("reset");
    check1("reset_state", 32'(state), 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    cycle("post_reset");

    // Power on
    btn_power = 1'b1; cycle("power_on");
    check1("power_on_state", 32'(state), 1);
    check1("power_on_on", 32'(on), 1);
    check1("power_on_gen", 32'(gen), 0);
    btn_power = 1'b0; cycle("power_rel");

    // Normal brew, led confirmed two cycles after gen rises
    btn_brew = 1'b1; cycle("brew_req");
    check1("brew_req_gen", 32'(gen), 1);
    btn_brew = 1'b0; cycle("req_wait");
    led = 1'b1;
    n = 0;
    for (int i = 0; i < 30 && done !== 1'b1; i++) begin
      cycle("brewing");
      if (state == 3'd3) n++;
    end
    check1("brew_len", n, BREW_CYCLES);
    check1("brew_done", 32'(done), 1);
    check1("brew_cups", 32'(cups), 1);
    led = 1'b0;
    cycle("back_idle");
    check1("idle_state", 32'(state), 1);
    check1("idle_gen", 32'(gen), 0);
    check1("idle_done", 32'(done), 0);

    // Ack timeout
    btn_brew = 1'b1; cycle("to_req");
    btn_brew = 1'b0;
    n = 1;
    for (int i = 0; i < 20 && fault !== 1'b1; i++) begin
      cycle("req_timeout");
      if (state == 3'd2) n++;
    end
    check1("req_len", n, ACK_TIMEOUT);
    check1("fault_on", 32'(on), 0);
    check1("fault_gen", 32'(gen), 0);
    check1("fault_flag", 32'(fault), 1);
    btn_brew = 1'b1; cycle("fault_brew");
    btn_brew = 1'b0; cycle("fault_brew_rel");
    check1("fault_hold", 32'(state), 5);
    pulse_power();
    check1("fault_clear", 32'(fault), 0);
    check1("fault_off", 32'(state), 0);

    // Led dropout at BREW cycle 3
    pulse_power();
    btn_brew = 1'b1; cycle("drop_req");
    btn_brew = 1'b0; led = 1'b1;
    for (int i = 0; i < 3; i++) cycle("drop_brew");
    check1("drop_in_brew", 32'(state), 3);
    led = 1'b0; cycle("drop_fault");
    check1("drop_fault", 32'(state), 5);
    check1("drop_cups", 32'(cups), 1);
    pulse_power();

    // Simultaneous power and brew in IDLE; power during BREW
    pulse_power();
    btn_power = 1'b1; btn_brew = 1'b1; cycle("both");
    check1("both_off", 32'(state), 0);
    btn_power = 1'b0; btn_brew = 1'b0; cycle("both_rel");
    check1("both_stay_off", 32'(state), 0);
    pulse_power();
    btn_brew = 1'b1; cycle("abort_req");
    btn_brew = 1'b0; led = 1'b1;
    repeat (3) cycle("abort_brew");
    btn_power = 1'b1; cycle("abort");
    check1("abort_off", 32'(state), 0);
    check1("abort_done", 32'(done), 0);
    check1("abort_cups", 32'(cups), 1);
    btn_power = 1'b0; led = 1'b0; cycle("abort_rel");

    // 17 brews saturate cups
    pulse_power();
    for (int k = 0; k < 17; k++) begin
      btn_brew = 1'b1; led = 1'b1; cycle("sat_req");
      btn_brew = 1'b0;
      for (int i = 0; i < 30 && state != 3'd1; i++) cycle("sat_run");
    end
    check1("cups_sat", 32'(cups), 15);

    // Async reset mid-brew, power held through reset
    btn_brew = 1'b1; cycle("rst_req");
    btn_brew = 1'b0;
    repeat (3) cycle("rst_brew");
    btn_power = 1'b1;
    #2 reset = 1'b0;
    #1;
    model_reset();
    check1("arst_on", 32'(on), 0);
    check1("arst_gen", 32'(gen), 0);
    check1("arst_done", 32'(done), 0);
    check1("arst_fault", 32'(fault), 0);
    check1("arst_cups", 32'(cups), 0);
    check1("arst_state", 32'(state), 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    led = 1'b0;
    repeat (2) cycle("held_power");
    check1("held_no_event", 32'(state), 0);
    btn_power = 1'b0; cycle("held_rel");
    pulse_power();
    check1("after_rst_idle", 32'(state), 1);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      btn_power = ($urandom_range(0, 19) == 0);
      btn_brew  = ($urandom_range(0, 3) == 0);
      led       = ($urandom_range(0, 9) != 0);
      cycle("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/coffee_panel.md
COFFEE_PANEL -- requirements
Module: coffee_panel

Interface
REQ-001 Parameter BREW_CYCLES, default 8, number of clock cycles gen is held high with led confirmed.
REQ-002 Parameter ACK_TIMEOUT, default 4, maximum cycles in REQ waiting for led=1 before fault.
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low; reset==0 forces reset state immediately, independent of clock.
REQ-005 btn_power  input  1  power button, synchronous level; action on rising edge only.
REQ-006 btn_brew  input  1  brew button, synchronous level; action on rising edge only.
REQ-007 led  input  1  brew-active indication returned by the coffee machine.
REQ-008 on  output  1  power request to the machine.
REQ-009 gen  output  1  brew request to the machine.
REQ-010 done  output  1  one-cycle pulse on brew completion.
REQ-011 fault  output  1  high while in FAULT.
REQ-012 cups  output  4  completed-brew count.
REQ-013 state  output  3  current FSM state encoding, for debug.

Function
REQ-014 Edge detect: btn_power/btn_brew each registered once; event = current 1 and previous 0; held buttons produce one event only.
REQ-015 States/encoding: OFF=0, IDLE=1, REQ=2, BREW=3, DONE=4, FAULT=5; unused codes go to OFF next cycle.
REQ-016 Outputs registered, Moore, from state: OFF on=0 gen=0; IDLE on=1 gen=0; REQ on=1 gen=1; BREW on=1 gen=1; DONE on=1 gen=0 done=1; FAULT on=0 gen=0 fault=1.
REQ-017 OFF: power event -> IDLE; brew event ignored.
REQ-018 IDLE: power event -> OFF; brew event -> REQ, wait counter cleared.
REQ-019 REQ: led=1 -> BREW, brew counter cleared; else wait counter increments; led still 0 when counter reaches ACK_TIMEOUT-1 -> FAULT.
REQ-020 BREW: brew counter increments each cycle; led=0 in any BREW cycle -> FAULT; counter reaches BREW_CYCLES-1 with led=1 -> DONE.
REQ-021 DONE: lasts exactly one cycle, then -> IDLE; cups increments by 1 on entry to DONE, saturating at 15.
REQ-022 FAULT: held until power event -> OFF; brew events ignored; cups unchanged.
REQ-023 Power event in REQ or BREW -> OFF (abort); no done pulse, cups unchanged.
REQ-024 Simultaneous power and brew events: power wins; brew event discarded.
REQ-025 Power event has priority over led timeout/dropout evaluated in the same cycle.
REQ-026 Counters sized ceil(log2(max(BREW_CYCLES,ACK_TIMEOUT)))+1 bits; never wrap within a state.
REQ-027 cups is cleared only by reset, not by OFF.

Reset
REQ-028 While reset==0: state=OFF, on=0, gen=0, done=0, fault=0, cups=0, counters=0, button history registers=1 (a button held through reset produces no event).
REQ-029 Reset asserted mid-brew aborts immediately; outputs reach reset values without waiting for a clock edge.
REQ-030 First power event accepted on a rising edge of the button after reset deasserts.

Verification
REQ-031 Reset, pulse btn_power -> state IDLE next cycle, on=1 gen=0.
REQ-032 From IDLE pulse btn_brew, drive led=1 two cycles after gen rises -> BREW for 8 cycles, done=1 for one cycle, cups 0->1, back to IDLE with gen=0.
REQ-033 From IDLE pulse btn_brew, keep led=0 -> FAULT after 4 cycles in REQ, on=0 gen=0 fault=1; btn_power pulse -> OFF, fault=0.
REQ-034 Drop led to 0 at BREW cycle 3 -> FAULT next cycle, cups unchanged.
REQ-035 Pulse btn_power and btn_brew together in IDLE -> OFF; separately, btn_power during BREW -> OFF, no done pulse.
REQ-036 Complete 17 brews -> cups saturates at 15; assert reset mid-brew -> all outputs 0 asynchronously, cups=0.
